// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        mem_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_in_t;

  typedef struct packed {
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
  } lsu_out_t;

  function automatic logic f3_legal(input logic load, input logic [2:0] f3);
    if (load) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication / byte enables, and load
// extraction with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_lane[gi*8 +: 8] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                                     (funct3[1:0] == 2'b01) ? wdata[(gi%2)*8 +: 8] :
                                                              wdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
  end

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one MEM-stage access -> one req/gnt/rvalid bus transaction.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_in_t    req_in;
  lsu_out_t   out_s;
  lsu_state_e state_reg, state_next;

  logic [1:0]  off_reg;
  logic [2:0]  f3_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic [3:0]  be_reg;
  logic        we_reg;

  logic        access, bad, accept, error_now, busy, fin_ok;
  logic        timeout_hit, err_done;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign req_in = {mem_valid, is_load, is_store, funct3, addr, wdata};

  // is_load wins when both are set, so a dual request decodes as a load
  assign access    = req_in.mem_valid & (req_in.is_load | req_in.is_store);
  assign bad       = ~f3_legal(req_in.is_load, req_in.funct3) |
                     is_misaligned(req_in.funct3, req_in.addr[1:0]);
  assign accept    = (state_reg == IDLE) & access & ~bad;
  assign error_now = (state_reg == IDLE) & access & bad;
  assign busy      = (state_reg == REQ) | (state_reg == RESP);
  assign fin_ok    = ((state_reg == REQ) & dmem_gnt & we_reg) |
                     ((state_reg == RESP) & dmem_rvalid);

  // One aligner serves both directions: live inputs while idle, latched ones later
  assign al_f3  = (state_reg == IDLE) ? req_in.funct3    : f3_reg;
  assign al_off = (state_reg == IDLE) ? req_in.addr[1:0] : off_reg;

  lsu_align u_align (
    .funct3     (al_f3),
    .offset     (al_off),
    .wdata      (req_in.wdata),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;
  logic             tmo_reg;

  assign timeout_hit = busy & (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_done    = tmo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tmo_reg <= 1'b0;
    end else begin
      cnt_reg <= busy ? cnt_reg + 1'b1 : '0;
      tmo_reg <= timeout_hit & ~fin_ok;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_done    = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = REQ;
      REQ:  if (dmem_gnt) state_next = we_reg ? DONE : RESP;
      RESP: if (dmem_rvalid) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // a completing handshake in the limit cycle still counts as success
    if (timeout_hit && !fin_ok) state_next = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      off_reg   <= 2'b00;
      f3_reg    <= 3'b000;
      addr_reg  <= '0;
      be_reg    <= 4'b0000;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        off_reg   <= req_in.addr[1:0];
        f3_reg    <= req_in.funct3;
        addr_reg  <= {req_in.addr[31:2], 2'b00};
        be_reg    <= req_in.is_load ? 4'b1111 : al_be;
        wdata_reg <= al_wdata;
        we_reg    <= ~req_in.is_load;
      end
      if (state_reg == RESP && dmem_rvalid) rdata_reg <= al_rdata;
    end
  end

  assign out_s.lsu_stall = accept | busy;
  assign out_s.lsu_done  = (state_reg == DONE);
  assign out_s.lsu_rdata = rdata_reg;
  assign out_s.lsu_err   = error_now | ((state_reg == DONE) & err_done);

  assign lsu_stall  = out_s.lsu_stall;
  assign lsu_done   = out_s.lsu_done;
  assign lsu_rdata  = out_s.lsu_rdata;
  assign lsu_err    = out_s.lsu_err;
  assign dmem_req   = (state_reg == REQ);
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_be    = be_reg;
  assign dmem_wdata = wdata_reg;

endmodule
